// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared types and defaults for the register-file ALU sequencer
// Purpose: op and FSM state encodings plus default address/data widths.
// Ports: none (package).
package regfile_seq_pkg;

   localparam int DEF_ADDR_W = 3;
   localparam int DEF_DATA_W = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_XOR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_READ  = 2'b01,
      S_EXEC  = 2'b10,
      S_WRITE = 2'b11
   } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// rtl/regfile_seq_alu.sv - combinational ALU for the register-file sequencer
// Purpose: computes rd value and carry/borrow from two operands.
// Ports: op (operation), a/b (operands), result (DATA_W, truncated), carry
//        (ADD carry-out, SUB borrow, 0 for logic ops).
module regfile_seq_alu
   import regfile_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  op_e               op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   // One extra bit: sum MSB is the carry-out, diff MSB is set exactly when a < b.
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
         end
         OP_SUB: begin
            result = diff[DATA_W-1:0];
            carry  = diff[DATA_W];
         end
         OP_AND: result = a & b;
         OP_XOR: result = a ^ b;
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/regfile_alu_sequencer.sv
// rtl/regfile_alu_sequencer.sv - port-A command sequencer: read two registers, ALU, write back
// Purpose: accepts rd <- rs1 op rs2 commands and drives register-file port A.
// Ports: clk, rst (sync, active-high); start enables acceptance;
//        cmd_valid/cmd_ready handshake with cmd_op, cmd_rd, cmd_rs1, cmd_rs2;
//        rf_raddr1/rf_raddr2 out, rf_rdata1/rf_rdata2 in (combinational reads);
//        rf_we/rf_waddr/rf_wdata write-back; busy, done pulse, carry flag.
module regfile_alu_sequencer
   import regfile_seq_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   output logic [ADDR_W-1:0] rf_raddr1,
   output logic [ADDR_W-1:0] rf_raddr2,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              busy,
   output logic              done,
   output logic              carry
);

   state_e            state;
   op_e               op_q;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;

   // Held low during reset so every output reads 0 while rst is asserted.
   assign cmd_ready = !rst && start && (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   regfile_seq_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_result),
      .carry  (alu_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= OP_ADD;
         rd_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rf_raddr1 <= '0;
         rf_raddr2 <= '0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         done      <= 1'b0;
         carry     <= 1'b0;
      end else begin
         rf_we <= 1'b0;
         done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  op_q      <= op_e'(cmd_op);
                  rd_q      <= cmd_rd;
                  // Addresses are registered here so they are stable for all of READ.
                  rf_raddr1 <= cmd_rs1;
                  rf_raddr2 <= cmd_rs2;
                  state     <= S_READ;
               end
            end
            S_READ: begin
               // Read data has settled for a full cycle; snapshot the operands so
               // rd == rs1/rs2 cannot disturb them once write-back begins.
               a_q   <= rf_rdata1;
               b_q   <= rf_rdata2;
               state <= S_EXEC;
            end
            S_EXEC: begin
               rf_we    <= 1'b1;
               done     <= 1'b1;
               rf_waddr <= rd_q;
               rf_wdata <= alu_result;
               carry    <= alu_carry;
               state    <= S_WRITE;
            end
            S_WRITE: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// tb/tb_regfile_alu_sequencer.sv - self-checking bench for regfile_alu_sequencer
module tb_regfile_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [2:0] cmd_rd = 3'd0;
   logic [2:0] cmd_rs1 = 3'd0;
   logic [2:0] cmd_rs2 = 3'd0;
   logic [2:0] rf_raddr1, rf_raddr2;
   logic [3:0] rf_rdata1, rf_rdata2;
   logic       rf_we;
   logic [2:0] rf_waddr;
   logic [3:0] rf_wdata;
   logic       busy, done, carry;

   logic [3:0] rf [8];
   logic [3:0] ref_rf [8];
   int         checks = 0;
   int         failures = 0;
   int         we_count = 0;

   regfile_alu_sequencer #(.ADDR_W(3), .DATA_W(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy(busy), .done(done), .carry(carry)
   );

   always #5 clk = ~clk;

   assign rf_rdata1 = rf[rf_raddr1];
   assign rf_rdata2 = rf[rf_raddr2];

   always @(posedge clk) begin
      if (rf_we) begin
         rf[rf_waddr] <= rf_wdata;
         we_count <= we_count + 1;
      end
   end

   // Reference ALU in plain integer arithmetic: returns {carry, result}.
   function automatic logic [4:0] model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      int ia, ib, r;
      logic c;
      ia = int'(a);
      ib = int'(b);
      c = 1'b0;
      case (op)
         2'd0: begin r = ia + ib; c = (r > 15); r = r % 16; end
         2'd1: begin r = ia - ib; c = (ia < ib); if (r < 0) r = r + 16; end
         2'd2: r = ia & ib;
         default: r = ia ^ ib;
      endcase
      return {c, r[3:0]};
   endfunction

   // Called at a negedge; returns at the negedge of the first IDLE cycle after WRITE.
   task automatic issue_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
      logic [4:0] e;
      int w;
      e = model(op, ref_rf[rs1], ref_rf[rs2]);
      cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_valid = 1'b1;
      #1;
      w = 0;
      while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
      checks++;
      if (!cmd_ready) begin
         failures++;
         $display("FAIL accept_timeout cmd_ready=%0b required=1", cmd_ready);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (rf_raddr1 !== rs1 || rf_raddr2 !== rs2 || busy !== 1'b1 || rf_we !== 1'b0) begin
         failures++;
         $display("FAIL read_cycle raddr1=%0d raddr2=%0d busy=%0b we=%0b required %0d %0d 1 0",
                  rf_raddr1, rf_raddr2, busy, rf_we, rs1, rs2);
      end
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL exec_cycle we=%0b done=%0b busy=%0b required 0 0 1", rf_we, done, busy);
      end
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b1 || done !== 1'b1 || rf_waddr !== rd || rf_wdata !== e[3:0] || carry !== e[4]) begin
         failures++;
         $display("FAIL write_cycle op=%0d we=%0b done=%0b waddr=%0d wdata=%0d carry=%0b required 1 1 %0d %0d %0b",
                  op, rf_we, done, rf_waddr, rf_wdata, carry, rd, e[3:0], e[4]);
      end
      ref_rf[rd] = e[3:0];
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || carry !== e[4] || cmd_ready !== start) begin
         failures++;
         $display("FAIL after_write we=%0b done=%0b busy=%0b carry=%0b ready=%0b required 0 0 0 %0b %0b",
                  rf_we, done, busy, carry, cmd_ready, e[4], start);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || rf_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || carry !== 1'b0 ||
          rf_raddr1 !== 3'd0 || rf_raddr2 !== 3'd0 || rf_waddr !== 3'd0 || rf_wdata !== 4'd0) begin
         failures++;
         $display("FAIL reset_outputs ready=%0b we=%0b done=%0b busy=%0b carry=%0b ra1=%0d ra2=%0d wa=%0d wd=%0d required all 0",
                  cmd_ready, rf_we, done, busy, carry, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || rf_we !== 1'b0) begin
         failures++;
         $display("FAIL reset_release ready=%0b busy=%0b we=%0b required 1 0 0", cmd_ready, busy, rf_we);
      end
   endtask

   task automatic test_directed();
      issue_cmd(2'd0, 3'd4, 3'd3, 3'd2);   // 7+5=12, carry 0
      issue_cmd(2'd0, 3'd5, 3'd3, 3'd4);   // back-to-back: 7+12=19 -> 3, carry 1
      issue_cmd(2'd1, 3'd6, 3'd2, 3'd3);   // 5-7 -> 14, borrow 1
      issue_cmd(2'd2, 3'd7, 3'd6, 3'd3);   // 14&7 = 6
      issue_cmd(2'd3, 3'd0, 3'd2, 3'd2);   // 5^5 = 0
      checks++;
      if (rf[5] !== 4'd3 || rf[6] !== 4'd14 || rf[7] !== 4'd6) begin
         failures++;
         $display("FAIL directed_rf r5=%0d r6=%0d r7=%0d required 3 14 6", rf[5], rf[6], rf[7]);
      end
   endtask

   task automatic test_start_gate();
      int base;
      base = we_count;
      start = 1'b0;
      cmd_op = 2'd1; cmd_rd = 3'd5; cmd_rs1 = 3'd4; cmd_rs2 = 3'd2; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (cmd_ready !== 1'b0 || rf_we !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_low cyc=%0d ready=%0b we=%0b busy=%0b required 0 0 0", i, cmd_ready, rf_we, busy);
         end
      end
      checks++;
      if (we_count !== base) begin
         failures++;
         $display("FAIL start_low_writes count=%0d required %0d", we_count, base);
      end
      start = 1'b1;
      issue_cmd(2'd1, 3'd5, 3'd4, 3'd2);   // 12-5 = 7
   endtask

   task automatic test_reset_abort();
      int base;
      int w;
      cmd_op = 2'd0; cmd_rd = 3'd1; cmd_rs1 = 3'd3; cmd_rs2 = 3'd2; cmd_valid = 1'b1;
      #1;
      w = 0;
      while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
      @(posedge clk); @(negedge clk);      // READ
      cmd_valid = 1'b0;
      @(negedge clk);                      // EXEC
      base = we_count;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || carry !== 1'b0) begin
         failures++;
         $display("FAIL abort_reset we=%0b busy=%0b done=%0b carry=%0b required 0 0 0 0", rf_we, busy, done, carry);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (we_count !== base || rf[1] !== 4'd0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_after writes=%0d r1=%0d ready=%0b busy=%0b required %0d 0 1 0",
                  we_count, rf[1], cmd_ready, busy, base);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
   endtask

   task automatic test_final_rf();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rf[i] !== ref_rf[i]) begin
            failures++;
            $display("FAIL final_rf r%0d=%0d required %0d", i, rf[i], ref_rf[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         rf[i] = 4'd0;
         ref_rf[i] = 4'd0;
      end
      rf[2] = 4'd5; ref_rf[2] = 4'd5;
      rf[3] = 4'd7; ref_rf[3] = 4'd7;
      @(negedge clk);
      test_reset();
      test_directed();
      test_start_gate();
      test_reset_abort();
      test_random();
      test_final_rf();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
